// File: rtl/delay_line_var.sv
`timescale 1ns/1ps
// delay_line_var: multichannel delay line with a runtime-selectable tap.
// The delay range is 0..MAX_DELAY. A parallel valid chain runs alongside the data.
// Also provided: clock enable, synchronous flush, an optional output register,
// and a sticky out-of-range flag.
module delay_line_var #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 1,
  parameter int MAX_DELAY = 16,
  parameter int DELAY_W   = 5,
  parameter int OUT_REG   = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ce,
  input  logic                         flush,
  input  logic [DELAY_W-1:0]           delay,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         in_valid,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic                         out_valid,
  output logic                         delay_err
);

  localparam int                 DW    = CHANNELS * WIDTH;
  localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

  if (MAX_DELAY < 1) begin : g_bad_max_delay
    $fatal(1, "delay_line_var: MAX_DELAY must be >= 1");
  end
  if ((2 ** DELAY_W) <= MAX_DELAY) begin : g_bad_delay_w
    $fatal(1, "delay_line_var: DELAY_W too narrow for MAX_DELAY");
  end

  logic [DW-1:0]       r_data [1:MAX_DELAY];
  logic [MAX_DELAY:1]  r_valid;
  logic [DELAY_W-1:0]  r_cur_delay;
  logic                r_delay_err;

  logic                w_range_err;
  logic [DW-1:0]       w_tap_data;
  logic                w_tap_valid;

  assign w_range_err = (delay > MAX_D);

  // Delay setting register (clamped) and sticky out-of-range flag; set beats flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cur_delay <= '0;
      r_delay_err <= 1'b0;
    end else begin
      r_cur_delay <= w_range_err ? MAX_D : delay;
      if (w_range_err)
        r_delay_err <= 1'b1;
      else if (flush)
        r_delay_err <= 1'b0;
    end
  end

  // Data stages shift on ce; flush deliberately leaves data untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= MAX_DELAY; k++) r_data[k] <= '0;
    end else if (ce) begin
      r_data[1] <= in_data;
      for (int k = 2; k <= MAX_DELAY; k++) r_data[k] <= r_data[k-1];
    end
  end

  // Valid chain: flush clears every stage and wins over an incoming valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (ce) begin
      r_valid[1] <= in_valid;
      for (int k = 2; k <= MAX_DELAY; k++) r_valid[k] <= r_valid[k-1];
    end
  end

  // Tap select: delay 0 bypasses to the input, which is held at 0 while in reset.
  always_comb begin
    w_tap_data  = '0;
    w_tap_valid = 1'b0;
    if (r_cur_delay == '0) begin
      if (rstn) begin
        w_tap_data  = in_data;
        w_tap_valid = in_valid;
      end
    end else begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        if (r_cur_delay == DELAY_W'(k)) begin
          w_tap_data  = r_data[k];
          w_tap_valid = r_valid[k];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;

    // Output stage: loads the tap on ce; flush clears only its valid bit.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (ce) r_out_data <= w_tap_data;
        if (flush)
          r_out_valid <= 1'b0;
        else if (ce)
          r_out_valid <= w_tap_valid;
      end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
  end else begin : g_out_comb
    assign out_data  = w_tap_data;
    assign out_valid = w_tap_valid;
  end

  assign delay_err = r_delay_err;

endmodule

// File: tb/tb_delay_line_var.sv
`timescale 1ns/1ps
// Bench for delay_line_var: two instances (combinational and registered output).
// A history-queue reference model is checked every cycle, plus literal pins on key events.
module tb_delay_line_var;

  localparam int MAXD = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ce = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  delay = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;

  logic [31:0] o0_data, o1_data;
  logic        o0_valid, o1_valid, o0_err, o1_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  delay_line_var #(.WIDTH(16), .CHANNELS(2), .MAX_DELAY(MAXD), .DELAY_W(5), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .ce(ce), .flush(flush), .delay(delay),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(o0_data), .out_valid(o0_valid), .delay_err(o0_err));

  delay_line_var #(.WIDTH(16), .CHANNELS(2), .MAX_DELAY(MAXD), .DELAY_W(5), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .ce(ce), .flush(flush), .delay(delay),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(o1_data), .out_valid(o1_valid), .delay_err(o1_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of samples in the order they entered, newest at the back.
  typedef struct { logic [31:0] d; logic v; } ent_t;
  ent_t        hist[$];
  int          m_cur = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_odata = '0;
  logic        m_ovalid = 1'b0;

  function automatic ent_t tap_of();
    ent_t t;
    t.d = '0;
    t.v = 1'b0;
    if (rstn) begin
      if (m_cur == 0) begin
        t.d = in_data;
        t.v = in_valid;
      end else if (m_cur <= hist.size()) begin
        t = hist[hist.size() - m_cur];
      end
    end
    return t;
  endfunction

  always @(posedge clk or negedge rstn) begin
    ent_t t;
    ent_t n;
    if (!rstn) begin
      hist.delete();
      m_cur = 0;
      m_err = 1'b0;
      m_odata = '0;
      m_ovalid = 1'b0;
    end else begin
      t = tap_of();
      if (ce) begin
        m_odata  = t.d;
        m_ovalid = t.v && !flush;
      end else if (flush) begin
        m_ovalid = 1'b0;
      end
      if (flush) foreach (hist[i]) hist[i].v = 1'b0;
      if (ce) begin
        n.d = in_data;
        n.v = in_valid && !flush;
        hist.push_back(n);
        if (hist.size() > MAXD) void'(hist.pop_front());
      end
      if (delay > MAXD) m_err = 1'b1;
      else if (flush) m_err = 1'b0;
      m_cur = (delay > MAXD) ? MAXD : int'(delay);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    ent_t t;
    t = tap_of();
    check("o0_data", o0_data, t.d);
    check("o0_valid", {31'd0, o0_valid}, {31'd0, t.v});
    check("o1_data", o1_data, m_odata);
    check("o1_valid", {31'd0, o1_valid}, {31'd0, m_ovalid});
    check("o0_err", {31'd0, o0_err}, {31'd0, m_err});
    check("o1_err", {31'd0, o1_err}, {31'd0, m_err});
  end

  function automatic logic [31:0] sd(input int i);
    return {16'(i + 1000), 16'(i)};
  endfunction

  task automatic cyc(input logic c, input logic f, input logic [4:0] d,
                     input logic v, input logic [31:0] x);
    ce = c; flush = f; delay = d; in_valid = v; in_data = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o0_valid", {31'd0, o0_valid}, 32'd0);
    check("rst_o1_data", o1_data, 32'd0);
    check("rst_o1_valid", {31'd0, o1_valid}, 32'd0);
    check("rst_err", {31'd0, o0_err}, 32'd0);
    rstn = 1'b1;

    // Fixed delay 3 ramp
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 5'd3, 1, sd(i));
      if (i == 2) check("d3_not_yet", {31'd0, o0_valid}, 32'd0);
      if (i == 3) begin
        check("d3_data", o0_data, sd(1));
        check("d3_valid", {31'd0, o0_valid}, 32'd1);
        check("d3_oreg_late", {31'd0, o1_valid}, 32'd0);
      end
      if (i == 4) begin
        check("d3_oreg_data", o1_data, sd(1));
        check("d3_oreg_valid", {31'd0, o1_valid}, 32'd1);
      end
    end

    // ce gating with delay 4
    cyc(1, 1, 5'd4, 0, 32'd0);
    for (int e = 1; e <= 8; e++) begin
      if (e % 2 == 1) cyc(1, 0, 5'd4, 1, (e == 1) ? sd(50) : sd(50 + e));
      else            cyc(0, 0, 5'd4, 1, sd(99));
      if (e == 6) check("ce_not_yet", {31'd0, o0_valid}, 32'd0);
      if (e == 7) begin
        check("ce_data", o0_data, sd(50));
        check("ce_valid", {31'd0, o0_valid}, 32'd1);
      end
      if (e == 8) check("ce_hold", o0_data, sd(50));
    end

    // Runtime delay change 5 -> 2 -> 0
    for (int i = 1; i <= 8; i++) cyc(1, 0, 5'd5, 1, sd(300 + i));
    cyc(1, 0, 5'd2, 1, sd(309));
    check("chg_data", o0_data, sd(308));
    check("chg_valid", {31'd0, o0_valid}, 32'd1);
    cyc(1, 0, 5'd0, 1, sd(310));
    check("bypass_data", o0_data, sd(310));

    // Clamp and sticky error
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 0, 5'd20, 1, sd(400 + i));
      if (i == 1) check("clamp_err", {31'd0, o0_err}, 32'd1);
    end
    check("clamp_data", o0_data, sd(402));
    for (int i = 1; i <= 3; i++) cyc(1, 0, 5'd4, 1, sd(450 + i));
    check("err_sticky", {31'd0, o1_err}, 32'd1);
    cyc(1, 1, 5'd4, 1, sd(500));
    check("err_flushed", {31'd0, o0_err}, 32'd0);
    cyc(1, 1, 5'd20, 1, sd(501));
    check("err_set_beats_flush", {31'd0, o0_err}, 32'd1);
    cyc(1, 1, 5'd4, 1, sd(502));

    // Flush with registered output, delay 6
    for (int i = 1; i <= 10; i++) cyc(1, 0, 5'd6, 1, sd(600 + i));
    check("fl_running", {31'd0, o1_valid}, 32'd1);
    cyc(1, 1, 5'd6, 1, sd(611));
    check("fl_cleared", {31'd0, o1_valid}, 32'd0);
    n = 0;
    do begin
      cyc(1, 0, 5'd6, 1, sd(620 + n));
      n++;
    end while (!o1_valid && n < 20);
    check("fl_return_adv", n, 32'd7);

    // Async reset mid-cycle
    cyc(1, 0, 5'd20, 1, sd(650));
    #2;
    rstn = 1'b0;
    #1;
    check("arst_o0_data", o0_data, 32'd0);
    check("arst_o0_valid", {31'd0, o0_valid}, 32'd0);
    check("arst_o1_data", o1_data, 32'd0);
    check("arst_o1_valid", {31'd0, o1_valid}, 32'd0);
    check("arst_err", {31'd0, o0_err}, 32'd0);
    delay = 5'd3;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    n = 0;
    do begin
      cyc(1, 0, 5'd3, 1, sd(700 + n));
      n++;
    end while (!o0_valid && n < 20);
    check("arst_refill_adv", n, 32'd3);

    // Randomized traffic
    begin
      logic [4:0] d;
      d = 5'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) d = 5'($urandom_range(0, 20));
        cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0), d,
            ($urandom_range(0, 3) != 0), $urandom);
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
